i2c_init_sequencer: RTL

- Upstream driver for the single-register I2C write block.
- On request, walks an init table of (reg_address, data) writes and timed delays, issuing one write transaction per entry. Typical use: sensor power-up configuration.
- Handles per-entry retry on NACK, a watchdog abort, and done/error reporting to the top-level controller.
- The table lives in a small sync ROM sub-module addressed by this block.

---
 rtl/i2c_seq_pkg.sv | 39 +++
 rtl/i2c_init_rom.sv | 44 ++++
 rtl/i2c_init_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C init-table sequencer and its ROM.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    START_WR  = 4'd3,
    WAIT_DONE = 4'd4,
    RETRY     = 4'd5,
    DELAY     = 4'd6,
    NEXT      = 4'd7,
    DONE      = 4'd8,
    FAIL      = 4'd9
  } seq_state_e;

  localparam int unsigned IS_DELAY_BIT = 16;
  localparam int unsigned HI_MSB       = 15;
  localparam int unsigned HI_LSB       = 8;
  localparam int unsigned LO_MSB       = 7;
  localparam int unsigned LO_LSB       = 0;
  localparam int unsigned RETRY_GAP    = 16;
  localparam int unsigned DELAY_W      = 48;

  typedef struct packed {
    logic       is_delay;
    logic [7:0] hi;
    logic [7:0] lo;
  } rom_entry_t;

  function automatic logic [16:0] wr_entry(input logic [7:0] reg_address, input logic [7:0] data);
    return {1'b0, reg_address, data};
  endfunction

  function automatic logic [16:0] delay_entry(input logic [15:0] ticks);
    return {1'b1, ticks};
  endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Synchronous init-table ROM (1-cycle read latency) holding the sensor power-up writes.
module i2c_init_rom
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  localparam int unsigned ADDR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [16:0]       data
);
  logic [16:0] data_d;
  logic [16:0] data_q;

  always_comb begin
    data_d = '0;
    case (int'(addr))
      0:  data_d = delay_entry(16'd2);
      1:  data_d = wr_entry(8'h88, 8'h00);
      2:  data_d = wr_entry(8'h80, 8'h01);
      3:  data_d = wr_entry(8'hFF, 8'h01);
      4:  data_d = wr_entry(8'h00, 8'h00);
      5:  data_d = wr_entry(8'h91, 8'h3C);
      6:  data_d = wr_entry(8'h00, 8'h01);
      7:  data_d = wr_entry(8'hFF, 8'h00);
      8:  data_d = wr_entry(8'h80, 8'h00);
      9:  data_d = wr_entry(8'h60, 8'h12);
      10: data_d = wr_entry(8'h44, 8'h00);
      11: data_d = wr_entry(8'h45, 8'h20);
      12: data_d = wr_entry(8'h47, 8'h08);
      13: data_d = wr_entry(8'h48, 8'h28);
      14: data_d = wr_entry(8'h67, 8'h00);
      15: data_d = wr_entry(8'h01, 8'hFF);
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks an init table issuing I2C register writes and delays, with NACK retry and watchdog.
// Optional SEQ_AUTO_START_EN: launch the sequence once after reset without an external go.
module i2c_init_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES     = 16,
  parameter logic [6:0]  DEV_ADDRESS     = 7'h29,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned DELAY_UNIT      = 100000,
  parameter int unsigned WATCHDOG_CYCLES = 2000000,
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [16:0]      rom_data,
  output logic             wr_start,
  output logic [6:0]       wr_dev_address,
  output logic [7:0]       wr_reg_address,
  output logic [7:0]       wr_data,
  input  logic             wr_busy,
  input  logic             wr_message_failure,
  output logic             wr_relinquish,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] error_index,
  output logic [3:0]       state_out
);
  localparam int unsigned WD_W  = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam int unsigned RT_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int unsigned GAP_W = $clog2(RETRY_GAP);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [RT_W-1:0]    RT_MAX   = RT_W'(MAX_RETRIES);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(RETRY_GAP - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [DELAY_W-1:0] UNIT     = DELAY_W'(DELAY_UNIT);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, rom_addr_q, rom_addr_d, err_idx_q, err_idx_d;
  logic [RT_W-1:0]    retry_q, retry_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [DELAY_W-1:0] dly_q, dly_d, dly_load;
  logic [7:0]         reg_q, reg_d, data_q, data_d;
  logic fail_q, fail_d, wr_busy_q, wr_busy_d;
  logic wr_start_q, wr_start_d, relinq_q, relinq_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic go_eff, busy_fall, fail_seen;
  rom_entry_t entry;

`ifdef SEQ_AUTO_START_EN
  logic auto_go_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) auto_go_q <= 1'b1;
    else          auto_go_q <= 1'b0;
  end
  assign go_eff = go | auto_go_q;
`else
  assign go_eff = go;
`endif

  assign entry     = rom_entry_t'(rom_data);
  assign dly_load  = DELAY_W'({entry.hi, entry.lo}) * UNIT;
  assign busy_fall = wr_busy_q & ~wr_busy;
  // A failure pulse coincident with the busy falling edge still marks the attempt failed.
  assign fail_seen = fail_q | wr_message_failure;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    err_idx_d  = err_idx_q;
    retry_d    = retry_q;
    gap_d      = gap_q;
    wdog_d     = wdog_q;
    dly_d      = dly_q;
    reg_d      = reg_q;
    data_d     = data_q;
    fail_d     = fail_q;
    wr_busy_d  = wr_busy;
    wr_start_d = wr_start_q;
    relinq_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    unique case (state_q)
      IDLE: if (go_eff) begin
        idx_d      = '0;
        rom_addr_d = '0;
        retry_d    = '0;
        fail_d     = 1'b0;
        error_d    = 1'b0;
        busy_d     = 1'b1;
        state_d    = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (entry.is_delay) begin
          dly_d   = dly_load;
          state_d = (dly_load == '0) ? NEXT : DELAY;
        end else begin
          reg_d      = entry.hi;
          data_d     = entry.lo;
          fail_d     = 1'b0;
          wdog_d     = '0;
          wr_start_d = 1'b1;
          state_d    = START_WR;
        end
      end
      START_WR: begin
        fail_d = fail_seen;
        if (wr_busy) begin
          wr_start_d = 1'b0;
          wdog_d     = '0;
          state_d    = WAIT_DONE;
        end else if (wdog_q == WD_LAST) begin
          wr_start_d = 1'b0;
          relinq_d   = 1'b1;
          gap_d      = '0;
          state_d    = RETRY;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        fail_d = fail_seen;
        if (busy_fall) begin
          gap_d   = '0;
          state_d = fail_seen ? RETRY : NEXT;
        end else if (wdog_q == WD_LAST) begin
          relinq_d = 1'b1;
          gap_d    = '0;
          state_d  = RETRY;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RETRY: begin
        if (retry_q >= RT_MAX) begin
          state_d = FAIL;
        end else if (gap_q == GAP_LAST) begin
          retry_d    = retry_q + 1'b1;
          fail_d     = 1'b0;
          wdog_d     = '0;
          wr_start_d = 1'b1;
          state_d    = START_WR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DELAY: begin
        if (dly_q <= DELAY_W'(1)) state_d = NEXT;
        else                      dly_d   = dly_q - 1'b1;
      end
      NEXT: begin
        retry_d = '0;
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d      = idx_q + 1'b1;
          rom_addr_d = idx_q + 1'b1;
          state_d    = FETCH;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      FAIL: begin
        error_d   = 1'b1;
        err_idx_d = idx_q;
        retry_d   = '0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      err_idx_q  <= '0;
      retry_q    <= '0;
      gap_q      <= '0;
      wdog_q     <= '0;
      dly_q      <= '0;
      reg_q      <= '0;
      data_q     <= '0;
      fail_q     <= 1'b0;
      wr_busy_q  <= 1'b0;
      wr_start_q <= 1'b0;
      relinq_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      err_idx_q  <= err_idx_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      wdog_q     <= wdog_d;
      dly_q      <= dly_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      fail_q     <= fail_d;
      wr_busy_q  <= wr_busy_d;
      wr_start_q <= wr_start_d;
      relinq_q   <= relinq_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign wr_start       = wr_start_q;
  assign wr_dev_address = DEV_ADDRESS;
  assign wr_reg_address = reg_q;
  assign wr_data        = data_q;
  assign wr_relinquish  = relinq_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign error_index    = err_idx_q;
  assign state_out      = state_q;

endmodule
